// File: rtl/sp_mem_arbiter.sv
// sp_mem_arbiter: round-robin arbiter sharing one single-port SRAM between two requesters.
// Define SP_MEM_ARB_LOCK_EN to build the bounded lock FSM honouring lock_i.
module sp_mem_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_LOCK   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  req_i,
  output logic [1:0]                  gnt_o,
  input  logic [1:0]                  lock_i,
  input  logic [2*ADDR_WIDTH-1:0]     addr_i,
  input  logic [1:0]                  we_i,
  input  logic [2*(DATA_WIDTH/8)-1:0] be_i,
  input  logic [2*DATA_WIDTH-1:0]     wdata_i,
  output logic [DATA_WIDTH-1:0]       rdata_o,
  output logic [1:0]                  rvalid_o,
  output logic                        CEN_o,
  output logic                        WEN_o,
  output logic [ADDR_WIDTH-1:0]       A_o,
  output logic [DATA_WIDTH-1:0]       D_o,
  output logic [DATA_WIDTH/8-1:0]     BE_o,
  input  logic [DATA_WIDTH-1:0]       Q_i
);
  localparam int BW = DATA_WIDTH / 8;
  logic       prio_q, prio_d;
  logic [1:0] rvalid_q, rvalid_d;
  logic [1:0] gnt_rr;
  logic       g, any;
  assign gnt_rr = (&req_i) ? (prio_q ? 2'b10 : 2'b01) : req_i;
  assign g      = gnt_o[1];
  assign any    = |gnt_o;
  assign CEN_o  = ~any;
  assign WEN_o  = ~(any & we_i[g]);
  assign A_o    = any ? (g ? addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : addr_i[ADDR_WIDTH-1:0]) : '0;
  assign D_o    = any ? (g ? wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_i[DATA_WIDTH-1:0]) : '0;
  assign BE_o   = any ? (g ? be_i[2*BW-1:BW] : be_i[BW-1:0]) : '0;
  assign rdata_o  = Q_i;
  assign rvalid_o = rvalid_q;
  assign rvalid_d = gnt_o;
`ifdef SP_MEM_ARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          p;
  assign gnt_o = (state_q == LOCK0) ? {1'b0, req_i[0]} :
                 (state_q == LOCK1) ? {req_i[1], 1'b0} : gnt_rr;
  // the lock ends on the grant that makes MAX_LOCK consecutive grants to the port
  always_comb begin
    prio_d     = prio_q;
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    p          = (state_q == LOCK1);
    if (state_q == IDLE) begin
      if (any) begin
        prio_d = ~g;
        if (lock_i[g] && MAX_LOCK > 1) begin
          state_d    = g ? LOCK1 : LOCK0;
          lock_cnt_d = CW'(1);
        end
      end
    end else begin
      if (any) lock_cnt_d = (lock_cnt_q == CW'(MAX_LOCK)) ? lock_cnt_q : lock_cnt_q + 1'b1;
      if (!req_i[p] || !lock_i[p] || lock_cnt_q >= CW'(MAX_LOCK - 1)) begin
        state_d = IDLE;
        prio_d  = ~p;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      rvalid_q   <= 2'b00;
      state_q    <= IDLE;
      lock_cnt_q <= '0;
    end else begin
      prio_q     <= prio_d;
      rvalid_q   <= rvalid_d;
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  logic lock_unused;
  assign lock_unused = ^lock_i ^ (MAX_LOCK > 0);
  assign gnt_o  = gnt_rr;
  assign prio_d = any ? ~g : prio_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q   <= 1'b0;
      rvalid_q <= 2'b00;
    end else begin
      prio_q   <= prio_d;
      rvalid_q <= rvalid_d;
    end
  end
`endif
endmodule

// File: tb/tb_sp_mem_arbiter.sv
// tb_sp_mem_arbiter: scoreboard bench for sp_mem_arbiter with a behavioural SRAM.
module tb_sp_mem_arbiter;
  localparam int DW = 64;
  localparam int AW = 10;
  localparam int BW = DW / 8;
  localparam int ML = 4;
  typedef struct {
    logic [1:0]    rv;
    bit            rd;
    logic [DW-1:0] data;
  } exp_t;
  logic clk = 0;
  logic rst_n = 0;
  logic [1:0] req_i = 0, lock_i = 0, we_i = 0;
  logic [2*AW-1:0] addr_i = 0;
  logic [2*BW-1:0] be_i = 0;
  logic [2*DW-1:0] wdata_i = 0;
  logic [DW-1:0] rdata_o, D_o, Q_i;
  logic [1:0] gnt_o, rvalid_o;
  logic CEN_o, WEN_o;
  logic [AW-1:0] A_o;
  logic [BW-1:0] BE_o;
  logic [DW-1:0] mem [0:1023];
  exp_t sb [$];
  exp_t e_chk;
  int errors = 0;
  int checks = 0;
  sp_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .gnt_o(gnt_o), .lock_i(lock_i),
    .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
    .rdata_o(rdata_o), .rvalid_o(rvalid_o), .CEN_o(CEN_o), .WEN_o(WEN_o),
    .A_o(A_o), .D_o(D_o), .BE_o(BE_o), .Q_i(Q_i)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!CEN_o) begin
      if (!WEN_o) begin
        for (int b = 0; b < BW; b++) if (BE_o[b]) mem[A_o][b*8 +: 8] <= D_o[b*8 +: 8];
      end else begin
        Q_i <= mem[A_o];
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) begin
      e_chk = sb.pop_front();
      checks++;
      if (rvalid_o !== e_chk.rv) begin
        errors++;
        $display("FAIL rvalid: got %b expected %b at %0t", rvalid_o, e_chk.rv, $time);
      end
      if (e_chk.rd) begin
        checks++;
        if (rdata_o !== e_chk.data) begin
          errors++;
          $display("FAIL rdata: got %h expected %h at %0t", rdata_o, e_chk.data, $time);
        end
      end
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_i = 0; lock_i = 0; we_i = 0;
      #1;
      sb.push_back('{2'b00, 1'b0, '0});
    end
  endtask
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0; req_i = 0; lock_i = 0; we_i = 0;
    sb.delete();
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset();
    #1;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt_o); end
    checks++; if (CEN_o !== 1'b1) begin errors++; $display("FAIL reset_cen: got %b expected 1", CEN_o); end
    checks++; if (WEN_o !== 1'b1) begin errors++; $display("FAIL reset_wen: got %b expected 1", WEN_o); end
    checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b expected 00", rvalid_o); end
    checks++; if (A_o !== '0) begin errors++; $display("FAIL reset_addr: got %h expected 0", A_o); end
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_single_read();
    @(negedge clk);
    req_i = 2'b01; we_i = 2'b00; addr_i = {10'd0, 10'h010};
    #1;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL read_gnt: got %b expected 01", gnt_o); end
    checks++; if (CEN_o !== 1'b0) begin errors++; $display("FAIL read_cen: got %b expected 0", CEN_o); end
    checks++; if (WEN_o !== 1'b1) begin errors++; $display("FAIL read_wen: got %b expected 1", WEN_o); end
    checks++; if (A_o !== 10'h010) begin errors++; $display("FAIL read_addr: got %h expected 010", A_o); end
    sb.push_back('{2'b01, 1'b1, 64'hDEADBEEF_CAFEF00D});
    idle(2);
  endtask
  task automatic test_write_read();
    @(negedge clk);
    req_i = 2'b10; we_i = 2'b10; addr_i = {10'd5, 10'd0};
    be_i = {8'h01, 8'h00}; wdata_i = {64'h11, 64'h0};
    #1;
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL wr_gnt: got %b expected 10", gnt_o); end
    checks++; if (WEN_o !== 1'b0) begin errors++; $display("FAIL wr_wen: got %b expected 0", WEN_o); end
    checks++; if (BE_o !== 8'h01) begin errors++; $display("FAIL wr_be: got %h expected 01", BE_o); end
    checks++; if (A_o !== 10'd5) begin errors++; $display("FAIL wr_addr: got %h expected 005", A_o); end
    checks++; if (D_o !== 64'h11) begin errors++; $display("FAIL wr_data: got %h expected 11", D_o); end
    sb.push_back('{2'b10, 1'b0, '0});
    @(negedge clk);
    req_i = 2'b01; we_i = 2'b00; addr_i = {10'd0, 10'd5}; be_i = 0; wdata_i = 0;
    #1;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rd5_gnt: got %b expected 01", gnt_o); end
    checks++; if (WEN_o !== 1'b1) begin errors++; $display("FAIL rd5_wen: got %b expected 1", WEN_o); end
    sb.push_back('{2'b01, 1'b1, 64'h01234567_89ABCD11});
    idle(2);
  endtask
  task automatic test_round_robin();
    logic [1:0] exp_g;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_i = 2'b11; we_i = 2'b00; addr_i = {10'h021, 10'h020};
      #1;
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (gnt_o !== exp_g) begin errors++; $display("FAIL rr_gnt[%0d]: got %b expected %b", i, gnt_o, exp_g); end
      sb.push_back('{exp_g, 1'b1, (exp_g == 2'b01) ? 64'hA0A0A0A0_00000020 : 64'hB1B1B1B1_00000021});
    end
    idle(2);
  endtask
  task automatic test_lock();
`ifdef SP_MEM_ARB_LOCK_EN
    logic [13:0] seq = 14'b01_01_01_01_10_01_10;
`else
    logic [13:0] seq = 14'b01_10_01_10_01_10_01;
`endif
    logic [1:0] exp_g;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req_i = 2'b11; we_i = 2'b00; addr_i = {10'h021, 10'h020};
      lock_i = (i < 5) ? 2'b01 : 2'b00;
      #1;
      exp_g = seq[13-2*i -: 2];
      checks++; if (gnt_o !== exp_g) begin errors++; $display("FAIL lock_gnt[%0d]: got %b expected %b", i, gnt_o, exp_g); end
      sb.push_back('{exp_g, 1'b1, (exp_g == 2'b01) ? 64'hA0A0A0A0_00000020 : 64'hB1B1B1B1_00000021});
    end
    idle(2);
  endtask
  task automatic test_reset_mid_read();
    sb.delete();
    @(negedge clk);
    req_i = 2'b10; we_i = 2'b00; addr_i = {10'h021, 10'h000};
    #1;
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL mid_gnt: got %b expected 10", gnt_o); end
    @(posedge clk);
    #3;
    checks++; if (rvalid_o !== 2'b10) begin errors++; $display("FAIL mid_pending: got %b expected 10", rvalid_o); end
    rst_n = 0; req_i = 2'b00;
    #1;
    checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL mid_drop: got %b expected 00", rvalid_o); end
    repeat (2) begin
      @(negedge clk);
      checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL mid_hold: got %b expected 00", rvalid_o); end
    end
    @(negedge clk);
    rst_n = 1; req_i = 2'b11; addr_i = {10'h021, 10'h020};
    #1;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL post_reset_gnt: got %b expected 01", gnt_o); end
    sb.push_back('{2'b01, 1'b1, 64'hA0A0A0A0_00000020});
    idle(2);
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    mem[10'h010] = 64'hDEADBEEF_CAFEF00D;
    mem[10'd5]   = 64'h01234567_89ABCDEF;
    mem[10'h020] = 64'hA0A0A0A0_00000020;
    mem[10'h021] = 64'hB1B1B1B1_00000021;
    Q_i = '0;
    test_reset();
    test_single_read();
    test_write_read();
    test_round_robin();
    test_lock();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
